// File: rtl/lcd_pkg.sv
// Shared opcodes, state encoding and the fixed panel-configuration byte table
// for the ST7735 SPI sequencer.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] COLMOD_565 = 8'h55;

    localparam logic [2:0] ST_INIT_SLP  = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT = 3'd1;
    localparam logic [2:0] ST_INIT_CFG  = 3'd2;
    localparam logic [2:0] ST_IDLE      = 3'd3;
    localparam logic [2:0] ST_HDR       = 3'd4;
    localparam logic [2:0] ST_PIX_HI    = 3'd5;
    localparam logic [2:0] ST_PIX_LO    = 3'd6;

    typedef enum logic [2:0] {
        INIT_SLP  = ST_INIT_SLP,
        INIT_WAIT = ST_INIT_WAIT,
        INIT_CFG  = ST_INIT_CFG,
        IDLE      = ST_IDLE,
        HDR       = ST_HDR,
        PIX_HI    = ST_PIX_HI,
        PIX_LO    = ST_PIX_LO
    } state_t;

    localparam logic [3:0] HDR_LAST = 4'd10;
    localparam logic [1:0] CFG_LAST = 2'd2;

    // {dc, byte} for the post-sleep configuration burst: COLMOD 565, DISPON
    function automatic logic [8:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = {1'b0, CMD_COLMOD};
            2'd1:    cfg_word = {1'b1, COLMOD_565};
            default: cfg_word = {1'b0, CMD_DISPON};
        endcase
    endfunction

endpackage

// File: rtl/lcd_hdr_rom.sv
// Address-window header table: index 0..10 -> {dc, byte} for CASET/RASET/RAMWR
// with the captured window coordinates sent big-endian as 16-bit values.
module lcd_hdr_rom
    import lcd_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  logic [3:0]         idx_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] y1_i,
    output logic               dc_o,
    output logic [7:0]         data_o
);

    logic [15:0] x0_w, x1_w, y0_w, y1_w;

    assign x0_w = 16'(x0_i);
    assign x1_w = 16'(x1_i);
    assign y0_w = 16'(y0_i);
    assign y1_w = 16'(y1_i);

    always_comb begin
        dc_o   = 1'b1;
        data_o = 8'h00;
        case (idx_i)
            4'd0:  begin dc_o = 1'b0; data_o = CMD_CASET; end
            4'd1:  data_o = x0_w[15:8];
            4'd2:  data_o = x0_w[7:0];
            4'd3:  data_o = x1_w[15:8];
            4'd4:  data_o = x1_w[7:0];
            4'd5:  begin dc_o = 1'b0; data_o = CMD_RASET; end
            4'd6:  data_o = y0_w[15:8];
            4'd7:  data_o = y0_w[7:0];
            4'd8:  data_o = y1_w[15:8];
            4'd9:  data_o = y1_w[7:0];
            4'd10: begin dc_o = 1'b0; data_o = CMD_RAMWR; end
            default: begin dc_o = 1'b1; data_o = 8'h00; end
        endcase
    end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// ST7735 command sequencer: runs panel power-up out of reset, then serves
// rectangle fills as one continuous SPI burst (window header + RGB565 pixels).
module lcd_spi_sequencer
    import lcd_pkg::*;
#(
    parameter logic [23:0] SLPOUT_WAIT = 24'd12_000_000,
    parameter int          COORD_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fill_req,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] y1,
    input  logic [15:0]        color,
    output logic               fill_ack,
    output logic               fill_err,
    output logic               fill_done,
    output logic               ready,
    output logic               spi_en,
    output logic [7:0]         spi_data,
    output logic               spi_dc,
    input  logic               spi_valid
);

    localparam int CNT_W = 2 * COORD_W + 1;
    localparam logic [COORD_W:0] SPAN_ONE = (COORD_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic               spi_en_q, spi_dc_q;
    logic [7:0]         spi_data_q;
    logic               ready_q, fill_ack_q, fill_err_q, fill_done_q;
    logic [23:0]        wait_q;
    logic [1:0]         cfg_idx_q;
    logic [3:0]         hdr_idx_q;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [15:0]        color_q;

    logic [COORD_W:0]   span_x_d, span_y_d;
    logic [CNT_W-1:0]   pix_cnt_d;
    logic [3:0]         hdr_idx_d;
    logic               rom_dc;
    logic [7:0]         rom_data;
    logic               byte_done;
    logic               window_bad;

    // A strobe from the shifter only means something while a burst is open
    assign byte_done  = spi_en_q & spi_valid;
    assign window_bad = (x1 < x0) || (y1 < y0);

    // Inclusive spans; 17 bits hold the full 256x256 = 65536 case
    assign span_x_d  = {1'b0, x1} - {1'b0, x0} + SPAN_ONE;
    assign span_y_d  = {1'b0, y1} - {1'b0, y0} + SPAN_ONE;
    assign pix_cnt_d = CNT_W'(span_x_d) * CNT_W'(span_y_d);
    assign hdr_idx_d = hdr_idx_q + 4'd1;

    lcd_hdr_rom #(
        .COORD_W (COORD_W)
    ) u_hdr_rom (
        .idx_i  (hdr_idx_d),
        .x0_i   (x0_q),
        .x1_i   (x1_q),
        .y0_i   (y0_q),
        .y1_i   (y1_q),
        .dc_o   (rom_dc),
        .data_o (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_SLP;
            spi_en_q    <= 1'b0;
            spi_data_q  <= 8'h00;
            spi_dc_q    <= 1'b0;
            ready_q     <= 1'b0;
            fill_ack_q  <= 1'b0;
            fill_err_q  <= 1'b0;
            fill_done_q <= 1'b0;
            wait_q      <= '0;
            cfg_idx_q   <= '0;
            hdr_idx_q   <= '0;
            pix_cnt_q   <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
        end else begin
            fill_ack_q  <= 1'b0;
            fill_err_q  <= 1'b0;
            fill_done_q <= 1'b0;
            case (state_q)
                INIT_SLP: begin
                    if (!spi_en_q) begin
                        spi_en_q   <= 1'b1;
                        spi_data_q <= CMD_SLPOUT;
                        spi_dc_q   <= 1'b0;
                    end else if (byte_done) begin
                        spi_en_q <= 1'b0;
                        wait_q   <= '0;
                        state_q  <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (wait_q == SLPOUT_WAIT - 24'd1) begin
                        spi_en_q               <= 1'b1;
                        {spi_dc_q, spi_data_q} <= cfg_word(2'd0);
                        cfg_idx_q              <= '0;
                        state_q                <= INIT_CFG;
                    end else begin
                        wait_q <= wait_q + 24'd1;
                    end
                end
                INIT_CFG: begin
                    if (byte_done) begin
                        if (cfg_idx_q == CFG_LAST) begin
                            spi_en_q <= 1'b0;
                            ready_q  <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            cfg_idx_q              <= cfg_idx_q + 2'd1;
                            {spi_dc_q, spi_data_q} <= cfg_word(cfg_idx_q + 2'd1);
                        end
                    end
                end
                IDLE: begin
                    if (fill_req) begin
                        x0_q    <= x0;
                        x1_q    <= x1;
                        y0_q    <= y0;
                        y1_q    <= y1;
                        color_q <= color;
                        if (window_bad) begin
                            fill_err_q <= 1'b1;
                        end else begin
                            fill_ack_q <= 1'b1;
                            pix_cnt_q  <= pix_cnt_d;
                            hdr_idx_q  <= '0;
                            spi_en_q   <= 1'b1;
                            spi_dc_q   <= 1'b0;
                            spi_data_q <= CMD_CASET;
                            ready_q    <= 1'b0;
                            state_q    <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (byte_done) begin
                        if (hdr_idx_q == HDR_LAST) begin
                            spi_dc_q   <= 1'b1;
                            spi_data_q <= color_q[15:8];
                            state_q    <= PIX_HI;
                        end else begin
                            hdr_idx_q  <= hdr_idx_d;
                            spi_dc_q   <= rom_dc;
                            spi_data_q <= rom_data;
                        end
                    end
                end
                PIX_HI: begin
                    if (byte_done) begin
                        spi_data_q <= color_q[7:0];
                        state_q    <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (byte_done) begin
                        pix_cnt_q <= pix_cnt_q - CNT_ONE;
                        if (pix_cnt_q == CNT_ONE) begin
                            fill_done_q <= 1'b1;
                            spi_en_q    <= 1'b0;
                            ready_q     <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            spi_data_q <= color_q[15:8];
                            state_q    <= PIX_HI;
                        end
                    end
                end
                default: begin
                    spi_en_q <= 1'b0;
                    state_q  <= INIT_SLP;
                end
            endcase
        end
    end

    assign fill_ack  = fill_ack_q;
    assign fill_err  = fill_err_q;
    assign fill_done = fill_done_q;
    assign ready     = ready_q;
    assign spi_en    = spi_en_q;
    assign spi_data  = spi_data_q;
    assign spi_dc    = spi_dc_q;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Self-checking bench: randomized SPI shifter timing and fill windows, checked
// against a byte-stream model built from opcodes, coordinates and pixel counts.
module tb_lcd_spi_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fill_req = 1'b0;
    logic [7:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [15:0] color = '0;
    logic       fill_ack, fill_err, fill_done, ready, spi_en, spi_dc;
    logic [7:0] spi_data;
    logic       spi_valid = 1'b0;

    always #5 clk = ~clk;

    lcd_spi_sequencer #(
        .SLPOUT_WAIT (24'd16),
        .COORD_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fill_req  (fill_req),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .color     (color),
        .fill_ack  (fill_ack),
        .fill_err  (fill_err),
        .fill_done (fill_done),
        .ready     (ready),
        .spi_en    (spi_en),
        .spi_data  (spi_data),
        .spi_dc    (spi_dc),
        .spi_valid (spi_valid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [8:0] obs[$];
    logic [8:0] exp_q[$];
    int n_ack, n_err, n_done, n_rise, n_fall, n_notready, ack_before_done;
    int ack_cyc, done_cyc, rise_cyc, fall_cyc, fall0_cyc, rdy_rise_cyc, last_v_cyc;
    bit en_prev, rdy_prev;
    bit fast = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        obs.delete();
        n_ack = 0; n_err = 0; n_done = 0; n_rise = 0; n_fall = 0; n_notready = 0;
        ack_before_done = 0; ack_cyc = 0; done_cyc = 0; rise_cyc = 0; fall_cyc = 0;
        fall0_cyc = 0; rdy_rise_cyc = 0; last_v_cyc = 0;
        en_prev = spi_en;
        rdy_prev = ready;
    endtask

    // One clock: observe this cycle's outputs, then play the SPI shifter
    task automatic tick();
        bit v;
        @(negedge clk);
        cyc++;
        if (spi_en && !en_prev) begin n_rise++; rise_cyc = cyc; end
        if (!spi_en && en_prev) begin
            if (n_fall == 0) fall0_cyc = cyc;
            n_fall++; fall_cyc = cyc;
        end
        en_prev = spi_en;
        if (fill_ack) begin n_ack++; ack_cyc = cyc; end
        if (fill_err) n_err++;
        if (fill_done) begin n_done++; done_cyc = cyc; ack_before_done = n_ack; end
        if (ready && !rdy_prev) rdy_rise_cyc = cyc;
        if (!ready) n_notready++;
        rdy_prev = ready;
        if (spi_en) v = fast || ($urandom_range(0, 2) == 0);
        else        v = ($urandom_range(0, 3) == 0);
        spi_valid = v;
        if (v && spi_en && !reset) begin
            obs.push_back({spi_dc, spi_data});
            last_v_cyc = cyc;
        end
    endtask

    task automatic wait_done(input int bound);
        int n0;
        n0 = n_done;
        for (int i = 0; i < bound && n_done == n0; i++) tick();
        if (n_done == n0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ack(input int bound);
        int n0;
        n0 = n_ack;
        for (int i = 0; i < bound && n_ack == n0; i++) tick();
        if (n_ack == n0) check_val("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready(input int bound);
        for (int i = 0; i < bound && !ready; i++) tick();
        if (!ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic build_init();
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h3A});
        exp_q.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b0, 8'h29});
    endtask

    // Appends the expected stream for one fill: window header then pixel pairs
    task automatic build_fill(input logic [7:0] a0, a1, b0, b1, input logic [15:0] c);
        int n;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, a0});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, a1});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, b0});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, b1});
        exp_q.push_back({1'b0, 8'h2C});
        n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    task automatic compare_stream(input string tag);
        int n_eq;
        bit bad;
        n_eq = 0;
        bad = 1'b0;
        check_val({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            if (obs[i] === exp_q[i]) n_eq++;
            else if (!bad) begin
                bad = 1'b1;
                check_val($sformatf("%s_byte%0d", tag, i), obs[i], exp_q[i]);
            end
        end
        check_val({tag, "_match"}, n_eq, exp_q.size());
    endtask

    task automatic do_fill(input logic [7:0] a0, a1, b0, b1, input logic [15:0] c);
        bit bad;
        int nbytes;
        bad = (a1 < a0) || (b1 < b0);
        x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c;
        clr();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        if (bad) begin
            repeat (4) tick();
            check_val("err_cnt", n_err, 1);
            check_val("err_no_ack", n_ack, 0);
            check_val("err_no_spi", n_rise, 0);
            check_val("err_ready", n_notready, 0);
        end else begin
            exp_q.delete();
            build_fill(a0, a1, b0, b1, c);
            wait_done(exp_q.size() * 20 + 100);
            check_val("ack_cnt", n_ack, 1);
            check_val("done_cnt", n_done, 1);
            check_val("burst_cnt", n_rise, 1);
            check_val("done_lat", done_cyc - last_v_cyc, 1);
            check_val("en_drop_lat", fall_cyc - last_v_cyc, 1);
            check_val("ready_after", ready, 1'b1);
            compare_stream("fill");
        end
        nbytes = obs.size();
        $display("fill x=%0d..%0d y=%0d..%0d color=%04h ack=%0d err=%0d done=%0d bytes=%0d",
                 a0, a1, b0, b1, c, n_ack, n_err, n_done, nbytes);
    endtask

    initial begin
        logic [7:0] a0, a1, b0, b1;
        bit hit;

        // Reset state
        clr();
        repeat (3) tick();
        check_val("rst_spi_en", spi_en, 1'b0);
        check_val("rst_spi_data", spi_data, 8'h00);
        check_val("rst_spi_dc", spi_dc, 1'b0);
        check_val("rst_ready", ready, 1'b0);
        check_val("rst_ack", fill_ack, 1'b0);
        check_val("rst_err", fill_err, 1'b0);
        check_val("rst_done", fill_done, 1'b0);

        // Power-up sequence
        clr();
        reset = 1'b0;
        wait_ready(500);
        build_init();
        compare_stream("init");
        check_val("init_gap", rise_cyc - fall0_cyc, 16);
        check_val("init_bursts", n_rise, 2);
        check_val("ready_lat", rdy_rise_cyc - last_v_cyc, 1);
        $display("init bytes=%0d gap=%0d", obs.size(), rise_cyc - fall0_cyc);

        do_fill(8'd0, 8'd1, 8'd0, 8'd1, 16'hF800);
        do_fill(8'd5, 8'd4, 8'd0, 8'd1, 16'h1234);
        do_fill(8'd9, 8'd9, 8'd7, 8'd7, 16'hA5C3);
        do_fill(8'd2, 8'd3, 8'd9, 8'd8, 16'h0001);

        // Request held across a whole fill
        x0 = 8'd3; x1 = 8'd4; y0 = 8'd1; y1 = 8'd2; color = 16'h07E0;
        clr();
        fill_req = 1'b1;
        wait_ack(10);
        wait_done(2000);
        check_val("held_ack_before_done", ack_before_done, 1);
        tick();
        check_val("held_second_ack", n_ack, 2);
        check_val("held_ack_lat", ack_cyc - done_cyc, 1);
        fill_req = 1'b0;
        wait_done(2000);
        check_val("held_done_cnt", n_done, 2);
        exp_q.delete();
        build_fill(8'd3, 8'd4, 8'd1, 8'd2, 16'h07E0);
        build_fill(8'd3, 8'd4, 8'd1, 8'd2, 16'h07E0);
        compare_stream("held");
        $display("held req acks=%0d dones=%0d bytes=%0d", n_ack, n_done, obs.size());

        // Randomized windows, including single-pixel and reversed edges
        for (int t = 0; t < 16; t++) begin
            int k;
            k  = $urandom_range(0, 5);
            a0 = 8'($urandom_range(1, 250));
            b0 = 8'($urandom_range(1, 250));
            a1 = a0 + 8'($urandom_range(0, 3));
            b1 = b0 + 8'($urandom_range(0, 3));
            if (k == 0) a1 = a0 - 8'd1;
            if (k == 1) b1 = b0 - 8'd1;
            if (k == 2) begin a1 = a0; b1 = b0; end
            do_fill(a0, a1, b0, b1, 16'($urandom));
        end

        // Full panel
        fast = 1'b1;
        do_fill(8'd0, 8'd127, 8'd0, 8'd159, 16'h5A3C);
        check_val("full_pix_bytes", obs.size() - 11, 40960);
        fast = 1'b0;

        // Reset while a pixel low byte is on the wire
        x0 = 8'd0; x1 = 8'd3; y0 = 8'd0; y1 = 8'd3; color = 16'h1234;
        clr();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (spi_en && spi_dc && spi_data == 8'h34 && obs.size() >= 12) hit = 1'b1;
        end
        check_val("mid_reach_pix_lo", hit, 1'b1);
        spi_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_val("mid_rst_spi_en", spi_en, 1'b0);
        check_val("mid_rst_ack", fill_ack, 1'b0);
        check_val("mid_rst_err", fill_err, 1'b0);
        check_val("mid_rst_done", fill_done, 1'b0);
        check_val("mid_rst_ready", ready, 1'b0);
        clr();
        reset = 1'b0;
        wait_ready(500);
        build_init();
        compare_stream("reinit");
        check_val("reinit_gap", rise_cyc - fall0_cyc, 16);
        $display("reset mid-burst reinit bytes=%0d", obs.size());

        do_fill(8'd10, 8'd12, 8'd20, 8'd21, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
